// File: rtl/mcu_output_fifo_pkg.sv
// Shared types for the MCU output FIFO: handshake FSM states and defaults.
package mcu_output_fifo_pkg;

   localparam int DEF_DATA_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESENT = 2'd1,
      RELEASE = 2'd2
   } state_t;

endpackage

// File: rtl/mcu_output_fifo_sync_fifo.sv
// Synchronous FIFO: registered storage, combinational head, occupancy-based flags.
module sync_fifo #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  full,
   output logic                  empty
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] CNT_FULL = DEPTH[DEPTH_LOG2:0];

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;

   assign dout  = mem[rd_ptr];
   assign full  = (count == CNT_FULL);
   assign empty = (count == '0);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/mcu_output_fifo.sv
// Queues trace words and hands them to the MCU over a four-phase rts/cts handshake.
module mcu_output_fifo
   import mcu_output_fifo_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int DEPTH_LOG2  = 4,
   parameter int CHANGE_ONLY = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [DATA_WIDTH-1:0] input_data,
   input  logic                  load_next,
   input  logic                  cts,
   output logic [DATA_WIDTH-1:0] output_data,
   output logic                  rts,
   output logic                  overflow,
   output logic [DEPTH_LOG2:0]   count
);

   state_t state;
   state_t state_next;

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   cts_s;

   logic [DATA_WIDTH-1:0] last_cap;
   logic [DATA_WIDTH-1:0] head;
   logic                  cap;
   logic                  push;
   logic                  pop;
   logic                  full;
   logic                  empty;

   for (genvar i = 0; i < SYNC_STAGES; i++) begin : g_sync
      if (i == 0) begin : g_first
         assign sync_d[i] = cts;
      end else begin : g_rest
         assign sync_d[i] = sync_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) sync_q <= '0;
      else       sync_q <= sync_d;
   end

   assign cts_s = sync_q[SYNC_STAGES-1];

   assign cap  = enable &&
                 ((CHANGE_ONLY != 0) ? (input_data != last_cap) : load_next);
   // A full FIFO still takes the word when the head leaves in the same cycle.
   assign push = cap && (!full || pop);

   sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (input_data),
      .dout  (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      state_next = state;
      pop        = 1'b0;
      unique case (state)
         IDLE: begin
            if (!empty && !cts_s) begin
               pop        = 1'b1;
               state_next = PRESENT;
            end
         end
         PRESENT: if (cts_s)  state_next = RELEASE;
         RELEASE: if (!cts_s) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign rts = (state == PRESENT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         output_data <= '0;
         last_cap    <= '0;
         overflow    <= 1'b0;
      end else begin
         state <= state_next;
         if (pop) output_data <= head;
         if (cap) last_cap <= input_data;
         if (cap && full && !pop) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mcu_output_fifo.sv
// Directed bench for mcu_output_fifo: vector table plus handshake corner sequences.
module tb_mcu_output_fifo;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [15:0] input_data;
   logic        load_next;
   logic        cts;

   logic [15:0] output_data;
   logic        rts;
   logic        overflow;
   logic [4:0]  count;

   logic [15:0] output_data0;
   logic        rts0;
   logic        overflow0;
   logic [4:0]  count0;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [15:0] data;
      logic        cts;
      logic        exp_rts;
      logic [15:0] exp_out;
      logic [4:0]  exp_cnt;
   } vec_t;

   vec_t tbl [10];

   always #5 clk = ~clk;

   mcu_output_fifo dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .input_data  (input_data),
      .load_next   (load_next),
      .cts         (cts),
      .output_data (output_data),
      .rts         (rts),
      .overflow    (overflow),
      .count       (count)
   );

   mcu_output_fifo #(.CHANGE_ONLY(0)) dut0 (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .input_data  (input_data),
      .load_next   (load_next),
      .cts         (cts),
      .output_data (output_data0),
      .rts         (rts0),
      .overflow    (overflow0),
      .count       (count0)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      cts        = 1'b0;
      load_next  = 1'b0;
      input_data = 16'h0;
      enable     = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic wait_rts(input logic val, input string name);
      int n = 0;
      while (rts !== val && n < 20) begin
         step();
         n++;
      end
      if (rts !== val) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: rts timeout, got %0b expected %0b", name, rts, val);
      end
   endtask

   task automatic next_word(input logic [15:0] exp, input string name);
      cts = 1'b1;
      wait_rts(1'b0, name);
      cts = 1'b0;
      wait_rts(1'b1, name);
      chk(name, output_data, exp);
   endtask

   task automatic last_release(input string name);
      cts = 1'b1;
      wait_rts(1'b0, name);
      cts = 1'b0;
      repeat (6) step();
      chk(name, {27'd0, count}, 32'd0);
      chk({name, "_rts"}, rts, 1'b0);
   endtask

   initial begin
      tbl[0] = '{16'h00A5, 1'b0, 1'b0, 16'h0000, 5'd1};
      tbl[1] = '{16'h00A5, 1'b0, 1'b1, 16'h00A5, 5'd0};
      tbl[2] = '{16'h00A5, 1'b1, 1'b1, 16'h00A5, 5'd0};
      tbl[3] = '{16'h00A5, 1'b1, 1'b1, 16'h00A5, 5'd0};
      tbl[4] = '{16'h00A5, 1'b1, 1'b0, 16'h00A5, 5'd0};
      tbl[5] = '{16'h00A5, 1'b0, 1'b0, 16'h00A5, 5'd0};
      tbl[6] = '{16'h00A5, 1'b0, 1'b0, 16'h00A5, 5'd0};
      tbl[7] = '{16'h00A5, 1'b0, 1'b0, 16'h00A5, 5'd0};
      tbl[8] = '{16'h1234, 1'b0, 1'b0, 16'h00A5, 5'd1};
      tbl[9] = '{16'h1234, 1'b0, 1'b1, 16'h1234, 5'd0};

      // reset state, with a held zero input that must not be captured
      do_reset();
      step();
      chk("rst_rts", rts, 1'b0);
      chk("rst_out", output_data, 16'h0);
      chk("rst_cnt", {27'd0, count}, 32'd0);
      chk("rst_ovf", overflow, 1'b0);

      for (int i = 0; i < 10; i++) begin
         input_data = tbl[i].data;
         cts        = tbl[i].cts;
         step();
         chk($sformatf("vec%0d_rts", i), rts, tbl[i].exp_rts);
         chk($sformatf("vec%0d_out", i), output_data, tbl[i].exp_out);
         chk($sformatf("vec%0d_cnt", i), {27'd0, count}, {27'd0, tbl[i].exp_cnt});
      end

      // burst of 5 words, drained in order
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         input_data = 16'hB000 + 16'(i);
         step();
      end
      chk("burst_cnt", {27'd0, count}, 32'd4);
      chk("burst_out", output_data, 16'hB001);
      chk("burst_rts", rts, 1'b1);
      for (int i = 2; i <= 5; i++) begin
         next_word(16'hB000 + 16'(i), $sformatf("burst_w%0d", i));
      end
      last_release("burst_end");

      // overflow: 18 words, the last one dropped
      do_reset();
      for (int i = 1; i <= 18; i++) begin
         input_data = 16'h0100 + 16'(i);
         step();
         if (i == 17) chk("ovf_pre", overflow, 1'b0);
      end
      chk("ovf_cnt", {27'd0, count}, 32'd16);
      chk("ovf_out", output_data, 16'h0101);
      chk("ovf_flag", overflow, 1'b1);
      for (int i = 2; i <= 17; i++) begin
         next_word(16'h0100 + 16'(i), $sformatf("ovf_w%0d", i));
      end
      last_release("ovf_end");
      chk("ovf_sticky", overflow, 1'b1);

      // full FIFO: push in the same cycle IDLE pops
      do_reset();
      for (int i = 1; i <= 17; i++) begin
         input_data = 16'h0200 + 16'(i);
         step();
      end
      chk("fp_full", {27'd0, count}, 32'd16);
      cts = 1'b1;
      wait_rts(1'b0, "fp_rel");
      cts = 1'b0;
      repeat (3) step();
      chk("fp_idle_rts", rts, 1'b0);
      input_data = 16'h0212;
      step();
      chk("fp_cnt", {27'd0, count}, 32'd16);
      chk("fp_ovf", overflow, 1'b0);
      chk("fp_rts", rts, 1'b1);
      chk("fp_out", output_data, 16'h0202);
      for (int i = 3; i <= 18; i++) begin
         next_word(16'h0200 + 16'(i), $sformatf("fp_w%0d", i));
      end
      last_release("fp_end");

      // strobe-triggered capture of a repeated value
      do_reset();
      input_data = 16'h1234;
      load_next  = 1'b1;
      repeat (3) step();
      load_next = 1'b0;
      step();
      chk("ld_cnt", {27'd0, count0}, 32'd2);
      chk("ld_rts", rts0, 1'b1);
      chk("ld_out", output_data0, 16'h1234);
      enable    = 1'b0;
      load_next = 1'b1;
      repeat (2) step();
      load_next = 1'b0;
      step();
      chk("ld_dis_cnt", {27'd0, count0}, 32'd2);
      enable = 1'b1;

      // reset while PRESENT with 3 queued, cts held high afterwards
      do_reset();
      for (int i = 1; i <= 4; i++) begin
         input_data = 16'h0300 + 16'(i);
         step();
      end
      chk("rp_cnt", {27'd0, count}, 32'd3);
      chk("rp_rts", rts, 1'b1);
      cts        = 1'b1;
      reset      = 1'b1;
      input_data = 16'h0;
      step();
      reset = 1'b0;
      chk("rp_rst_rts", rts, 1'b0);
      chk("rp_rst_out", output_data, 16'h0);
      chk("rp_rst_cnt", {27'd0, count}, 32'd0);
      chk("rp_rst_ovf", overflow, 1'b0);
      repeat (3) step();
      input_data = 16'h0399;
      step();
      repeat (4) step();
      chk("rp_hold_cnt", {27'd0, count}, 32'd1);
      chk("rp_hold_rts", rts, 1'b0);
      chk("rp_hold_out", output_data, 16'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
